// File: rtl/bram_ctrl_pkg.sv
// Shared types for the single-port BRAM initiator.
//   state_t : controller FSM states (reset hold, fill sweep, normal operation)
//   is_busy : true while the controller owns the RAM (reset hold or fill sweep)
package bram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s != S_RUN);
  endfunction

endpackage

// File: rtl/bram_1p_ctrl.sv
// Initiator for a single-port, no-change-mode block RAM with a 1-cycle
// registered read. Word requests arrive on a valid/ready channel and are
// forwarded to the BRAM pins; read data returns on a valid/ready response
// channel with backpressure. After reset, and on clear_i, the whole memory
// is filled with INIT_VALUE before requests are accepted.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                request a refill of the memory with INIT_VALUE
//   busy_o                 high during reset hold and fill sweep
//   req_valid_i/ready_o    request handshake
//   req_we_i/addr_i/wdata_i  request payload (1 = write)
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (straight from the BRAM output register)
//   bram_en_o/we_o/addr_o/wdata_o  BRAM control and data-in pins
//   bram_rdata_i           BRAM data-out (registered, 1-cycle latency)
module bram_1p_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int                     RAM_WIDTH     = 8,
  parameter int                     RAM_ADDR_BITS = 10,
  parameter bit                     INIT_ENABLE   = 1'b1,
  parameter logic [RAM_WIDTH-1:0]   INIT_VALUE    = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  output logic                     busy_o,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [RAM_ADDR_BITS-1:0] req_addr_i,
  input  logic [RAM_WIDTH-1:0]     req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [RAM_WIDTH-1:0]     rsp_rdata_o,
  output logic                     bram_en_o,
  output logic                     bram_we_o,
  output logic [RAM_ADDR_BITS-1:0] bram_addr_o,
  output logic [RAM_WIDTH-1:0]     bram_wdata_o,
  input  logic [RAM_WIDTH-1:0]     bram_rdata_i
);

  state_t                     state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       clear_eff;
  logic                       fire;

  // Without a fill sweep there is nothing to restart, so clear_i is ignored.
  assign clear_eff = INIT_ENABLE && clear_i;
  assign fire      = (state_q == S_RUN) && req_valid_i && req_ready_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      S_RESET: begin
        state_d = INIT_ENABLE ? S_INIT : S_RUN;
        cnt_d   = '0;
      end
      S_INIT: begin
        // A clear mid-sweep restarts from address 0 and takes priority
        // over finishing on the last address.
        if (clear_eff) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (clear_eff) begin
          // Pending response is dropped; the memory is about to be rewritten.
          state_d     = S_INIT;
          cnt_d       = '0;
          rsp_valid_d = 1'b0;
        end else if (fire && !req_we_i) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o  = 1'b0;
    bram_en_o    = 1'b0;
    bram_we_o    = 1'b0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    unique case (state_q)
      S_INIT: begin
        bram_en_o    = 1'b1;
        bram_we_o    = 1'b1;
        bram_addr_o  = cnt_q;
        bram_wdata_o = INIT_VALUE;
      end
      S_RUN: begin
        // No-change mode: a write leaves the BRAM output register alone, so
        // writes may pass a held response. A read needs a free (or freeing)
        // response slot because it would overwrite the BRAM output.
        req_ready_o  = !clear_eff && (req_we_i || !rsp_valid_q || rsp_ready_i);
        bram_en_o    = fire;
        bram_we_o    = fire && req_we_i;
        bram_addr_o  = req_addr_i;
        bram_wdata_o = req_wdata_i;
      end
      default: ;
    endcase
  end

  assign busy_o      = is_busy(state_q);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = bram_rdata_i;

endmodule

// File: tb/tb_bram_1p_ctrl.sv
module tb_bram_1p_ctrl;

  localparam int          AW    = 4;
  localparam int          DW    = 8;
  localparam int          DEPTH = 16;
  localparam logic [7:0]  IV    = 8'hA5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          busy_o;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          bram_en_o;
  logic          bram_we_o;
  logic [AW-1:0] bram_addr_o;
  logic [DW-1:0] bram_wdata_o;
  logic [DW-1:0] bram_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bram_1p_ctrl #(
    .RAM_WIDTH    (DW),
    .RAM_ADDR_BITS(AW),
    .INIT_ENABLE  (1'b1),
    .INIT_VALUE   (IV)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .busy_o      (busy_o),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .bram_en_o   (bram_en_o),
    .bram_we_o   (bram_we_o),
    .bram_addr_o (bram_addr_o),
    .bram_wdata_o(bram_wdata_o),
    .bram_rdata_i(bram_rdata_i)
  );

  // Single-port no-change BRAM: output register only updates on a read.
  logic [DW-1:0] ram [DEPTH];
  always_ff @(posedge clk_i) begin
    if (bram_en_o) begin
      if (bram_we_o) ram[bram_addr_o] <= bram_wdata_o;
      else           bram_rdata_i     <= ram[bram_addr_o];
    end
  end

  // Reference model: memory contents plus one pending response slot.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            pend = 1'b0;
  logic [DW-1:0] pend_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One RUN-phase cycle: apply inputs at the falling edge, check settled
  // outputs against the model, then advance the model as the rising edge will.
  task automatic drive(input bit v, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit rr);
    bit exp_rdy, fire;
    @(negedge clk_i);
    req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = d;
    rsp_ready_i = rr; clear_i = 1'b0;
    #1;
    exp_rdy = we || !pend || rr;
    fire    = v && exp_rdy;
    chk("busy_run", busy_o, 0);
    chk("rsp_valid", rsp_valid_o, pend);
    if (pend) chk("rsp_rdata", rsp_rdata_o, pend_data);
    chk("req_ready", req_ready_o, exp_rdy);
    chk("bram_en", bram_en_o, fire);
    chk("bram_we", bram_we_o, fire && we);
    if (fire) chk("bram_addr", bram_addr_o, a);
    if (fire && we) chk("bram_wdata", bram_wdata_o, d);
    if (fire && we) ref_mem[a] = d;
    if (fire && !we) begin
      pend = 1'b1;
      pend_data = ref_mem[a];
    end else if (rr) begin
      pend = 1'b0;
    end
  endtask

  // Follow a busy period from the current sample point until busy_o drops,
  // checking the fill writes go to 0,1,2,... with the fill value.
  task automatic measure_busy(output int n, output int writes, output bit ok);
    n = 0; writes = 0; ok = 1'b1;
    while (busy_o === 1'b1 && n < 100) begin
      if (bram_en_o === 1'b1 && bram_we_o === 1'b1) begin
        if (bram_addr_o !== AW'(writes) || bram_wdata_o !== IV) ok = 1'b0;
        writes++;
      end
      if (req_ready_o !== 1'b0) ok = 1'b0;
      n++;
      @(negedge clk_i);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, w, k;
    bit ok;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rst_busy", busy_o, 1);
    chk("rst_en", bram_en_o, 0);
    chk("rst_we", bram_we_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);

    // 1: release, 17 busy cycles with 16 fill writes, then read addr 7
    @(negedge clk_i); rst_ni = 1'b1; #1;
    measure_busy(n, w, ok);
    chk("t1_busy_cycles", n, 17);
    chk("t1_fill_writes", w, 16);
    chk("t1_fill_order", ok, 1);
    drive(1, 0, 4'd7, 8'h00, 1);
    drive(0, 0, 4'd0, 8'h00, 1);
    chk("t1_rdata_a5", rsp_rdata_o, 8'hA5);
    drive(0, 0, 4'd0, 8'h00, 1);

    // 2: write then read back on the next cycle
    drive(1, 1, 4'd3, 8'h3C, 1);
    drive(1, 0, 4'd3, 8'h00, 1);
    drive(0, 0, 4'd0, 8'h00, 1);
    chk("t2_rdata_3c", rsp_rdata_o, 8'h3C);

    // 3: backpressure with a write passing a held response
    drive(1, 1, 4'd1, 8'h11, 1);
    drive(1, 0, 4'd1, 8'h00, 0);
    drive(1, 0, 4'd2, 8'h00, 0);
    chk("t3_read_blocked", req_ready_o, 0);
    drive(1, 1, 4'd5, 8'h55, 0);
    chk("t3_write_passes", req_ready_o, 1);
    drive(0, 0, 4'd0, 8'h00, 0);
    chk("t3_rdata_held", rsp_rdata_o, 8'h11);
    drive(1, 0, 4'd2, 8'h00, 1);
    chk("t3_drain_fire", bram_en_o, 1);
    drive(1, 0, 4'd5, 8'h00, 1);
    drive(0, 0, 4'd0, 8'h00, 1);
    chk("t3_rdata_55", rsp_rdata_o, 8'h55);

    // 4: streamed reads, one per cycle
    for (int i = 0; i < 4; i++) drive(1, 0, AW'(i), 8'h00, 1);
    drive(0, 0, 4'd0, 8'h00, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++)
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
            bit'($urandom_range(0, 3) != 0));
    drive(0, 0, 4'd0, 8'h00, 1);

    // 5: clear with a response pending
    drive(1, 0, 4'd3, 8'h00, 0);
    @(negedge clk_i);
    clear_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 4'd4; rsp_ready_i = 1'b0;
    #1;
    chk("t5_clear_ready", req_ready_o, 0);
    chk("t5_clear_en", bram_en_o, 0);
    chk("t5_pending", rsp_valid_o, 1);
    @(negedge clk_i);
    clear_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    #1;
    chk("t5_rsp_dropped", rsp_valid_o, 0);
    pend = 1'b0;
    measure_busy(n, w, ok);
    chk("t5_busy_cycles", n, 16);
    chk("t5_fill_writes", w, 16);
    chk("t5_fill_order", ok, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 0, AW'(i), 8'h00, 1);
    drive(0, 0, 4'd0, 8'h00, 1);

    // 6: reset in the middle of a sweep
    @(negedge clk_i);
    clear_i = 1'b1; #1;
    @(negedge clk_i);
    clear_i = 1'b0; #1;
    k = 0;
    while (!(busy_o === 1'b1 && bram_addr_o === 4'd9) && k < 40) begin
      @(negedge clk_i); #1;
      k++;
    end
    chk("t6_reached_cnt9", bram_addr_o, 4'd9);
    rst_ni = 1'b0;
    #1;
    chk("t6_async_en", bram_en_o, 0);
    chk("t6_async_busy", busy_o, 1);
    chk("t6_async_ready", req_ready_o, 0);
    chk("t6_async_rsp", rsp_valid_o, 0);
    @(negedge clk_i); rst_ni = 1'b1; #1;
    pend = 1'b0;
    measure_busy(n, w, ok);
    chk("t6_busy_cycles", n, 17);
    chk("t6_fill_writes", w, 16);
    chk("t6_fill_order", ok, 1);
    drive(1, 0, 4'd9, 8'h00, 1);
    drive(1, 0, 4'd15, 8'h00, 1);
    drive(0, 0, 4'd0, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
